// File: rtl/fetch_unit.sv
// fetch_unit: prefetching instruction fetch stage with a variable-latency memory port,
// an in-order {pc, instr} queue toward decode, and redirect flushing of in-flight fetches.
module fetch_unit #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_debug
);
    localparam int QW = $clog2(DEPTH);
    localparam int OW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(DEPTH + 1) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] fl_pc   [MAX_OUTSTANDING];
    logic [QW-1:0]   q_head, q_tail;
    logic [OW-1:0]   fl_head, fl_tail;
    logic [CW-1:0]   occupancy, outstanding, discard;
    logic            req_fire, rsp_keep, pop;

    function automatic logic [OW-1:0] fl_next(input logic [OW-1:0] p);
        return (p == OW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check: every non-discarded in-flight fetch already owns a queue slot.
    assign imem_req_valid = reset && !redirect_valid && outstanding < CW'(MAX_OUTSTANDING)
                            && occupancy + outstanding - discard < CW'(DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign pc_debug       = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && discard == '0 && !redirect_valid;
    assign instr_valid    = occupancy != '0;
    assign pop            = instr_valid && instr_ready;
    assign instr_out      = q_instr[q_head];
    assign instr_pc       = q_pc[q_head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            q_head      <= '0;
            q_tail      <= '0;
            fl_head     <= '0;
            fl_tail     <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) fl_pc[i] <= '0;
        end else begin
            if (req_fire) begin
                fl_pc[fl_tail] <= fetch_pc;
                fl_tail        <= fl_next(fl_tail);
            end
            if (imem_rsp_valid) fl_head <= fl_next(fl_head);
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (rsp_keep) begin
                q_pc[q_tail]    <= fl_pc[fl_head];
                q_instr[q_tail] <= imem_rsp_data;
            end
            if (redirect_valid) begin
                fetch_pc  <= redirect_pc & ~XLEN'(3);
                q_head    <= '0;
                q_tail    <= '0;
                occupancy <= '0;
                // Everything still in flight after this cycle belongs to the old path.
                discard   <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                q_tail    <= q_tail + QW'(rsp_keep);
                q_head    <= q_head + QW'(pop);
                occupancy <= occupancy + CW'(rsp_keep) - CW'(pop);
                discard   <= discard - CW'(imem_rsp_valid && discard != '0);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a latency-programmable memory model;
// expected {pc, instr} pairs are queued by stimulus and checked by a separate monitor.
module tb_fetch_unit;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    logic        clk = 0;
    logic        reset = 0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        instr_valid;
    logic        instr_ready = 0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] pc_debug;

    int    total = 0, bad = 0;
    int    lat = 1, cyc = 0, tb_out = 0, acc_cnt = 0;
    bit    rdy_rand = 0;
    exp_t  exp_q[$];
    mreq_t mq[$];

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .pc_debug(pc_debug)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0010_0093 + (a >> 2);
    endfunction

    // Memory: samples handshakes mid-cycle, answers in order lat cycles after acceptance.
    always begin
        logic        acc, fire;
        logic [31:0] a;
        @(negedge clk);
        acc  = imem_req_valid && imem_req_ready;
        fire = imem_rsp_valid;
        a    = imem_req_addr;
        @(posedge clk);
        #1;
        if (!reset) begin
            mq.delete();
            tb_out = 0;
        end else begin
            if (fire) begin
                void'(mq.pop_front());
                tb_out--;
            end
            if (acc) begin
                mq.push_back('{a, cyc + lat});
                tb_out++;
                acc_cnt++;
            end
        end
        cyc++;
        imem_rsp_valid = reset && mq.size() > 0 && mq[0].due <= cyc;
        imem_rsp_data  = imem_rsp_valid ? mem_word(mq[0].addr) : 32'h0;
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: in-order comparison of every decode handshake against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            total++;
            if (tb_out > 2) begin
                bad++;
                $display("FAIL outstanding got=%0d max=2", tb_out);
            end
        end
        if (instr_valid && instr_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (instr_pc !== e.pc || instr_out !== e.instr) begin
                bad++;
                $display("FAIL pop got pc=%h instr=%h exp pc=%h instr=%h", instr_pc, instr_out, e.pc, e.instr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{start + 32'(4 * i), mem_word(start + 32'(4 * i))});
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && exp_q.size() > 0; i++) step(1);
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    // Leaves the bench in cycle 0 after release.
    task automatic do_reset();
        reset = 0;
        redirect_valid = 0;
        exp_q.delete();
        step(2);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_pc_debug", pc_debug, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_pc", instr_pc, 0);
        acc_cnt = 0;
        reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Streaming at 1 instruction/cycle.
        lat = 1; instr_ready = 1;
        do_reset();
        push_seq(0, 20);
        #1;
        chk("c0_req_valid", 32'(imem_req_valid), 1);
        chk("c0_req_addr", imem_req_addr, 0);
        step(1);
        chk("c1_instr_valid", 32'(instr_valid), 0);
        step(1);
        chk("c2_instr_valid", 32'(instr_valid), 1);
        chk("c2_instr_pc", instr_pc, 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("no_bubble", 32'(instr_valid), 1);
        end
        drain(100);

        // Back-pressure: queue fills to DEPTH, fetch stalls, nothing lost.
        lat = 1; instr_ready = 0;
        do_reset();
        push_seq(0, 12);
        step(10);
        chk("bp_req_valid", 32'(imem_req_valid), 0);
        chk("bp_accepted", 32'(acc_cnt), 4);
        chk("bp_instr_valid", 32'(instr_valid), 1);
        chk("bp_head_pc", instr_pc, 0);
        instr_ready = 1;
        drain(100);

        // Redirect with two outstanding and a response in the redirect cycle.
        lat = 2; instr_ready = 1;
        do_reset();
        for (int i = 0; i < 20 && !(tb_out == 2 && imem_rsp_valid); i++) step(1);
        chk("redir_window", 32'(tb_out == 2 && imem_rsp_valid), 1);
        redirect_valid = 1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req_valid", 32'(imem_req_valid), 0);
        step(1);
        redirect_valid = 0;
        #1;
        chk("redir_t1_req_valid", 32'(imem_req_valid), 1);
        chk("redir_t1_req_addr", imem_req_addr, 32'h0000_0100);
        chk("redir_t1_instr_valid", 32'(instr_valid), 0);
        push_seq(32'h0000_0100, 8);
        step(1);
        chk("redir_t2_instr_valid", 32'(instr_valid), 0);
        step(1);
        chk("redir_t3_instr_valid", 32'(instr_valid), 0);
        step(1);
        chk("redir_t4_instr_valid", 32'(instr_valid), 1);
        drain(100);

        // Latency 3, random memory and decode readiness.
        lat = 3; rdy_rand = 1;
        do_reset();
        push_seq(0, 30);
        for (int i = 0; i < 800 && exp_q.size() > 0; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        drain(0);
        rdy_rand = 0;

        // Fetch address wraps past the top of the address space.
        lat = 1; instr_ready = 0;
        do_reset();
        step(3);
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 0;
        #1;
        chk("wrap_pc_debug", pc_debug, 32'hFFFF_FFFC);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        push_seq(32'hFFFF_FFFC, 4);
        instr_ready = 1;
        step(1);
        chk("wrap_next_pc", pc_debug, 32'h0000_0000);
        drain(100);

        // Asynchronous reset with a full queue, then restart from RESET_PC.
        lat = 1; instr_ready = 0;
        do_reset();
        step(10);
        chk("full_instr_valid", 32'(instr_valid), 1);
        #1;
        reset = 0;
        #1;
        chk("async_instr_valid", 32'(instr_valid), 0);
        chk("async_req_valid", 32'(imem_req_valid), 0);
        chk("async_pc_debug", pc_debug, 0);
        do_reset();
        push_seq(0, 6);
        instr_ready = 1;
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
